// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, FSM states and FIFO entry layout for the fetch unit
package fetch_pkg;
  localparam int XLEN = 32;
  localparam int FETCH_DEPTH = 2;
  typedef enum logic [1:0] {RESET, RUN, FLUSH} state_t;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] word;
  } entry_t;
endpackage

// File: rtl/inst_fifo.sv
// inst_fifo: 2-entry synchronous FIFO with flush, used for instructions and request tags
module inst_fifo
  import fetch_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);
  logic [W-1:0] mem [FETCH_DEPTH];
  logic rp, wp;
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rp <= 1'b0;
      wp <= 1'b0;
      count <= 2'd0;
    end else if (flush) begin
      rp <= 1'b0;
      wp <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with 2 outstanding requests, 2-entry buffer and redirect flush
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jreq,
  input  logic [31:0] jval,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);
  state_t state, state_n;
  logic [31:0] fetch_pc, pc_n, tag_pc;
  logic [1:0] kill_cnt, kill_n, tag_cnt, fifo_cnt;
  logic grant, push, pop;
  entry_t head;
  assign grant = imem_req & imem_gnt;
  assign pop = inst_valid & inst_ready;
  // responses in the redirect cycle belong to the old stream and are dropped
  assign push = imem_rvalid & (state != FLUSH) & ~jreq;
  assign imem_req = (state != RESET) && ({1'b0, tag_cnt} + {1'b0, fifo_cnt} < 3'd2);
  assign imem_addr = fetch_pc;
  assign inst_valid = fifo_cnt != 2'd0;
  assign inst = head.word;
  assign inst_pc = head.pc;
  always_comb begin
    pc_n = jreq ? {jval[31:2], 2'b00} : grant ? fetch_pc + 32'd4 : fetch_pc;
    kill_n = jreq ? tag_cnt + {1'b0, grant} - {1'b0, imem_rvalid}
           : (state == FLUSH && imem_rvalid) ? kill_cnt - 2'd1 : kill_cnt;
    state_n = (kill_n != 2'd0) ? FLUSH : RUN;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RESET;
      fetch_pc <= RESET_PC;
      kill_cnt <= 2'd0;
    end else begin
      state <= state_n;
      fetch_pc <= pc_n;
      kill_cnt <= kill_n;
    end
  // tag queue tracks every granted address, killed or not, so its count is the outstanding count
  inst_fifo #(.W(XLEN)) u_tag_q (
    .clk(clk),
    .rst_n(rst_n),
    .flush(1'b0),
    .push(grant),
    .pop(imem_rvalid),
    .din(fetch_pc),
    .dout(tag_pc),
    .count(tag_cnt)
  );
  inst_fifo #(.W($bits(entry_t))) u_inst_q (
    .clk(clk),
    .rst_n(rst_n),
    .flush(jreq),
    .push(push),
    .pop(pop),
    .din({tag_pc, imem_rdata}),
    .dout(head),
    .count(fifo_cnt)
  );
  assert property (@(posedge clk) disable iff (!rst_n) !(imem_rvalid && fifo_cnt == 2'd2));
endmodule
